// File: rtl/proc_pkg.sv
// Shared encodings for the ALU issue path.
// Instruction layout: [8:6] op, [5:3] ra, [2:0] rb/funct.
package proc_pkg;

    localparam int DW_DEF   = 8;
    localparam int NREG_DEF = 8;
    localparam int AW       = 3;

    typedef enum logic [2:0] {
        OP_SYS = 3'b000,
        OP_A1  = 3'b001,
        OP_A2  = 3'b010,
        OP_A3  = 3'b011,
        OP_A4  = 3'b100,
        OP_A5  = 3'b101,
        OP_A6  = 3'b110,
        OP_A7  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        F_NOP = 3'b000,
        F_DEC = 3'b001,
        F_INC = 3'b010,
        F_SUB = 3'b011
    } funct_e;

    localparam logic [1:0] ALU_LOGIC = 2'b00;
    localparam logic [1:0] ALU_DEC   = 2'b01;
    localparam logic [1:0] ALU_INC   = 2'b10;
    localparam logic [1:0] ALU_SUB   = 2'b11;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] ra;
        logic [2:0] rb;
    } instr_t;

endpackage

// File: rtl/reg_file.sv
// NREG x DW register file: two combinational reads, one write.
// Forwarding of same-cycle writes is handled by the caller.
module reg_file #(
    parameter int DW   = 8,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr_a,
    output logic [DW-1:0] rd_a,
    input  logic [AW-1:0] addr_b,
    output logic [DW-1:0] rd_b,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);

    logic [DW-1:0] mem_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wa] <= wd;
        end
    end

    assign rd_a = mem_q[addr_a];
    assign rd_b = mem_q[addr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage ahead of the ALU: decode, operand read with
// writeback forwarding, busy scoreboard and a valid/ready output register.
module alu_issue_stage
    import proc_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8:0]      instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      alu_cmd,
    output logic [1:0]      ALU_Op,
    output logic [DW-1:0]   inA,
    output logic [DW-1:0]   inB,
    output logic [AW-1:0]   dest,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [DW-1:0]   wb_data,
    output logic            illegal,
    output logic [NREG-1:0] busy_vec
);

    instr_t ins;
    assign ins = instr;

    logic            is_sys;
    logic            is_nop;
    logic            is_rsv;
    logic            issues;
    logic            use_b;
    logic [AW-1:0]   b_addr;
    logic [1:0]      cls;
    logic [2:0]      cmd;
    logic [DW-1:0]   rd_a;
    logic [DW-1:0]   rd_b;
    logic [DW-1:0]   fwd_a;
    logic [DW-1:0]   fwd_b;
    logic [DW-1:0]   opnd_b;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] busy_eff;
    logic            hazard;
    logic            accept;
    logic            acc_issue;

    logic            out_valid_q, out_valid_d;
    logic [2:0]      cmd_q, cmd_d;
    logic [1:0]      cls_q, cls_d;
    logic [DW-1:0]   ina_q, ina_d;
    logic [DW-1:0]   inb_q, inb_d;
    logic [AW-1:0]   dest_q, dest_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            illegal_q, illegal_d;

    reg_file #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (AW)
    ) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr_a (ins.ra),
        .rd_a   (rd_a),
        .addr_b (b_addr),
        .rd_b   (rd_b),
        .we     (wb_en),
        .wa     (wb_addr),
        .wd     (wb_data)
    );

    always_comb begin
        is_sys = (ins.op == OP_SYS);
        is_nop = is_sys && (ins.rb == F_NOP);
        is_rsv = is_sys && ins.rb[2];
        issues = !is_nop && !is_rsv;
        use_b  = !is_sys || (ins.rb == F_SUB);
        b_addr = is_sys ? '0 : ins.rb;
        cmd    = is_sys ? 3'b000 : ins.op;
        cls    = ALU_LOGIC;
        if (is_sys) begin
            unique case (ins.rb[1:0])
                2'b01:   cls = ALU_DEC;
                2'b10:   cls = ALU_INC;
                2'b11:   cls = ALU_SUB;
                default: cls = ALU_LOGIC;
            endcase
        end
    end

    // A same-cycle writeback both clears the busy bit and supplies the value.
    always_comb begin
        clr_vec  = wb_en ? (NREG'(1) << wb_addr) : '0;
        busy_eff = busy_q & ~clr_vec;
        hazard   = issues &&
                   (busy_eff[ins.ra] || (use_b && busy_eff[b_addr]));
        fwd_a    = (wb_en && wb_addr == ins.ra) ? wb_data : rd_a;
        fwd_b    = (wb_en && wb_addr == b_addr) ? wb_data : rd_b;
        opnd_b   = use_b ? fwd_b : '0;
    end

    assign in_ready  = (!out_valid_q || out_ready) && !hazard;
    assign accept    = in_valid && in_ready;
    assign acc_issue = accept && issues;

    always_comb begin
        out_valid_d = out_valid_q;
        cmd_d       = cmd_q;
        cls_d       = cls_q;
        ina_d       = ina_q;
        inb_d       = inb_q;
        dest_d      = dest_q;
        illegal_d   = illegal_q || (accept && is_rsv);
        busy_d      = busy_q & ~clr_vec;
        if (acc_issue) begin
            out_valid_d    = 1'b1;
            cmd_d          = cmd;
            cls_d          = cls;
            ina_d          = fwd_a;
            inb_d          = opnd_b;
            dest_d         = ins.ra;
            busy_d[ins.ra] = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            cmd_q       <= '0;
            cls_q       <= '0;
            ina_q       <= '0;
            inb_q       <= '0;
            dest_q      <= '0;
            busy_q      <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            cmd_q       <= cmd_d;
            cls_q       <= cls_d;
            ina_q       <= ina_d;
            inb_q       <= inb_d;
            dest_q      <= dest_d;
            busy_q      <= busy_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_cmd   = cmd_q;
    assign ALU_Op    = cls_q;
    assign inA       = ina_q;
    assign inB       = inb_q;
    assign dest      = dest_q;
    assign busy_vec  = busy_q;
    assign illegal   = illegal_q;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue stage sitting directly upstream of the ALU. Accepts 9-bit instructions and decodes them into `alu_cmd`/`ALU_Op`. Reads both operands from an internal 8x8 register file and presents them to the ALU through a registered valid/ready output. The ALU result returns through a writeback port, with forwarding, and a per-register busy scoreboard stalls read-after-write hazards.

## Interface
Parameters:
- `DW`, 8, data width (ALU datapath width).
- `NREG`, 8, register count; register address width = $clog2(NREG) = 3.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  instruction accepted this cycle when high with `in_valid`.
- `instr`  in  9  instruction: [8:6] op, [5:3] ra (dest and source A), [2:0] rb/funct.
- `out_valid`  out  1  issued operation held at ALU inputs.
- `out_ready`  in  1  ALU/downstream consumes the operation.
- `alu_cmd`  out  3  ALU command.
- `ALU_Op`  out  2  ALU operation class.
- `inA`, `inB`  out  DW  operands.
- `dest`  out  3  writeback register for the issued operation.
- `wb_en`  in  1  write `wb_data` to `wb_addr`.
- `wb_addr`  in  3  writeback register.
- `wb_data`  in  DW  writeback value.
- `illegal`  out  1  sticky: reserved encoding seen.
- `busy_vec`  out  NREG  scoreboard state (debug).

## Operation
- Decode by op:
  - 001..111: `ALU_Op`=00, `alu_cmd`=op, inA=R[ra], inB=R[rb].
  - 000 + funct 000: NOP, consumed, nothing issued.
  - 000 + funct 001: DEC, `ALU_Op`=01, inA=R[ra], inB=0.
  - 000 + funct 010: INC, `ALU_Op`=10, inA=R[ra], inB=0.
  - 000 + funct 011: SUB, `ALU_Op`=11, inA=R[ra], inB=R[0].
  - 000 + funct 1xx: reserved; consumed, not issued, `illegal` set until reset.
- For every issued operation `alu_cmd` is 000 unless `ALU_Op`=00, and `dest`=ra.
- Sources read: ra always. rb for op 001..111; R0 for SUB.
- Hazard: a source's `busy_vec` bit is set and not cleared by `wb_en`/`wb_addr` in the same cycle.
- `in_ready` = (!out_valid || out_ready) && !hazard. NOP and reserved encodings ignore hazards.
- Accept = `in_valid && in_ready`. For an issuing instruction the output register loads and `out_valid` goes to 1.
- If `out_ready` arrives with no accept, `out_valid` goes to 0.
- Output register holds all fields stable while `out_valid && !out_ready`.
- Scoreboard:
  - Accepting an issuing instruction sets busy[ra].
  - `wb_en` clears busy[wb_addr].
  - When the same register is set and cleared in one cycle, the set wins.
- Forwarding: if `wb_en` and `wb_addr` equals a source in the accept cycle, that operand takes `wb_data`, not the stale register value.
- Register write at the same edge; R0 is writable.

## Timing
- Reset values:
  - `out_valid`=0, `alu_cmd`=0, `ALU_Op`=0, `inA`=0, `inB`=0, `dest`=0.
  - `illegal`=0, `busy_vec`=0, all registers 0.
  - `in_ready` follows its equation, so it is 1 after reset.
- Reset mid-operation discards the held operation and all busy bits immediately (async).
- Issue latency: 1 cycle, accept edge to `out_valid`=1.
- Throughput: 1 instruction/cycle when hazard-free and `out_ready`=1.
- `in_ready` is combinational from `instr`, `busy_vec`, `wb_*`, `out_valid`, `out_ready`. It has no dependence on `in_valid`.
- `wb_en` is honoured every cycle regardless of handshake state.

## Structure
- Package `proc_pkg`:
  - op and funct encodings as enums.
  - `ALU_Op` class constants (LOGIC=00, DEC=01, INC=10, SUB=11).
  - Instruction field struct {op, ra, rb}.
  - `DW`/`NREG` defaults.
- Sub-module `reg_file`:
  - NREG x DW, two combinational read ports, one write port.
  - Async active-low reset to 0.
  - Write-through forwarding stays in the issue stage.
- Scoreboard, decode and output register are local to `alu_issue_stage`.

## Test plan
- Reset, then write R1=0x05 and R2=0x03 via wb. Issue op 011 ra=1 rb=2 -> next cycle `out_valid`=1, `ALU_Op`=00, `alu_cmd`=011, inA=0x05, inB=0x03, dest=1, busy_vec=0x02.
- Hold `out_ready`=0 for 3 cycles with a second instruction waiting -> outputs stable, `in_ready`=0. Raise `out_ready` -> second instruction issues next cycle.
- RAW hazard: issue INC ra=1, then op 100 ra=3 rb=1 -> `in_ready`=0 until `wb_en`=1, wb_addr=1, wb_data=0x06. In that same cycle, accept with inB=0x06 (forwarded).
- SUB ra=4 with R4=0x10, R0=0x01 -> `ALU_Op`=11, inA=0x10, inB=0x01. Instruction 9'b000_000_000 -> consumed, no `out_valid`.
- Instruction 9'b000_101_100 -> no issue, `illegal`=1 and remains 1 through subsequent legal traffic until `rst_n` low.
- Assert `rst_n`=0 while `out_valid`=1 with busy_vec=0x0A -> immediately `out_valid`=0, busy_vec=0, registers 0.
